gst_dmasnd_engine: RTL

// - Parametrised DMA sound playback engine for the STE/Falcon-class shifter path.
// - Buffers words fetched by the MCU sound DMA (SLOAD_N strobes) in a FIFO with a true occupancy count.
// - Plays them out at 6.25/12.5/25/50 kHz in mono-8, stereo-8 or stereo-16 format.
// - Drives offset-binary left/right samples to the board audio DAC/mixer.

---
 rtl/gst_dmasnd_engine.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/gst_dmasnd_engine.sv
// rtl/gst_dmasnd_engine.sv - DMA sound playback engine: fetch FIFO, rate divider, format unpack
//
// Buffers 16-bit words delivered by the sound DMA (SLOAD_N strobes) in a FIFO
// and plays them out as offset-binary left/right samples at 6.25/12.5/25/50 kHz
// in stereo-8, mono-8 or stereo-16 format.
//
// Optional feature macro: DMASND_UNDERRUN_EN adds the sticky underrun output.
//
// Ports:
//   clk32          in   system clock (32 MHz)
//   resb           in   asynchronous active-low reset
//   sndmode[3:0]   in   [1:0] rate 00=6.25k 01=12.5k 10=25k 11=50k,
//                       [3:2] format 00=stereo8 01=mono8 10=stereo16 11=stereo8
//   flush          in   synchronous FIFO clear
//   SLOAD_N        in   DMA load strobe, falling edge marks MDIN valid
//   MDIN[15:0]     in   RAM data bus
//   SREQ           out  DMA request, FIFO has room for another fetch
//   audio_left     out  left sample, offset binary, OUT_W bits
//   audio_right    out  right sample, offset binary, OUT_W bits
//   sample_strobe  out  one-cycle pulse when audio outputs update
//   fifo_level     out  FIFO word count 0..DEPTH
//   underrun       out  sticky starvation flag (DMASND_UNDERRUN_EN only)

module gst_dmasnd_engine #(
  parameter int FIFO_ADDR_BITS = 3,
  parameter int CLK_DIV        = 640,
  parameter int OUT_W          = 8
) (
  input  logic                      clk32,
  input  logic                      resb,
  input  logic [3:0]                sndmode,
  input  logic                      flush,
  input  logic                      SLOAD_N,
  input  logic [15:0]               MDIN,
`ifdef DMASND_UNDERRUN_EN
  output logic                      underrun,
`endif
  output logic                      SREQ,
  output logic [OUT_W-1:0]          audio_left,
  output logic [OUT_W-1:0]          audio_right,
  output logic                      sample_strobe,
  output logic [FIFO_ADDR_BITS:0]   fifo_level
);

  localparam int AW    = FIFO_ADDR_BITS;
  localparam int CW    = FIFO_ADDR_BITS + 1;
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;

  // Base tick divider and rate prescaler
  logic [9:0]       cnt_q, cnt_d;
  logic [2:0]       presc_q, presc_d;
  logic             aclk_en_q, aclk_en_d;
  logic             tick;
  logic             rate_ok;

  // Write path
  logic             sload_q, sload_d;
  logic             wr_req, wr_ok, full;

  // FIFO state
  logic [15:0]      fifo_mem [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW-1:0]    rp_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic             bytesel_q, bytesel_d;
  logic [15:0]      word0, word1;

  // Read / output
  logic             have_data;
  logic             do_read;
  logic [1:0]       npop_fmt;
  logic [1:0]       npop;
  logic [7:0]       mono_byte;
  logic [15:0]      samp_l16, samp_r16;
  logic [OUT_W-1:0] left_q, left_d;
  logic [OUT_W-1:0] right_q, right_d;
  logic             strobe_q, strobe_d;
  // Low sample bits are discarded when OUT_W < 16
  logic             unused_lsbs;

`ifdef DMASND_UNDERRUN_EN
  logic             underrun_q, underrun_d;
`endif

  // Base tick and aclk_en generation
  always_comb begin
    tick    = (cnt_q == 10'(CLK_DIV - 1));
    cnt_d   = tick ? 10'd0 : cnt_q + 10'd1;
    presc_d = presc_q + {2'b00, tick};
    // Slower rates take every 2nd/4th/8th tick, keyed on the prescaler
    // value seen at the tick.
    case (sndmode[1:0])
      2'b11:   rate_ok = 1'b1;
      2'b10:   rate_ok = ~presc_q[0];
      2'b01:   rate_ok = (presc_q[1:0] == 2'b00);
      default: rate_ok = (presc_q == 3'b000);
    endcase
    aclk_en_d = tick & rate_ok;
  end

  // Write qualification; fullness is judged before any pop this cycle
  always_comb begin
    sload_d = SLOAD_N;
    wr_req  = sload_q & ~SLOAD_N;
    full    = (count_q == CW'(DEPTH));
    wr_ok   = wr_req & ~full;
  end

  always_ff @(posedge clk32) begin
    if (wr_ok && !flush) begin
      fifo_mem[wp_q] <= MDIN;
    end
  end

  // Format unpack and FIFO pointer update
  always_comb begin
    rp_nxt    = rp_q + AW'(1);
    word0     = fifo_mem[rp_q];
    word1     = fifo_mem[rp_nxt];
    have_data = 1'b0;
    npop_fmt  = 2'd0;
    mono_byte = bytesel_q ? word0[7:0] : word0[15:8];
    samp_l16  = 16'h0000;
    samp_r16  = 16'h0000;

    case (sndmode[3:2])
      2'b10: begin
        have_data = (count_q >= CW'(2));
        samp_l16  = word0 ^ 16'h8000;
        samp_r16  = word1 ^ 16'h8000;
        npop_fmt  = 2'd2;
      end
      2'b01: begin
        have_data = (count_q != '0);
        samp_l16  = {mono_byte ^ 8'h80, 8'h00};
        samp_r16  = {mono_byte ^ 8'h80, 8'h00};
        // The word is only released after its low byte has played
        npop_fmt  = bytesel_q ? 2'd1 : 2'd0;
      end
      default: begin
        have_data = (count_q != '0);
        samp_l16  = {word0[15:8] ^ 8'h80, 8'h00};
        samp_r16  = {word0[7:0]  ^ 8'h80, 8'h00};
        npop_fmt  = 2'd1;
      end
    endcase

    do_read     = aclk_en_q & have_data;
    npop        = do_read ? npop_fmt : 2'd0;
    unused_lsbs = ^{samp_l16, samp_r16};

    left_d    = left_q;
    right_d   = right_q;
    strobe_d  = do_read;
    bytesel_d = bytesel_q;
    if (do_read) begin
      left_d  = samp_l16[15 -: OUT_W];
      right_d = samp_r16[15 -: OUT_W];
      if (sndmode[3:2] == 2'b01) begin
        bytesel_d = ~bytesel_q;
      end
    end

    rp_d    = rp_q + AW'(npop);
    wp_d    = wr_ok ? wp_q + AW'(1) : wp_q;
    count_d = count_q + CW'(wr_ok) - CW'(npop);

    // flush discards everything in flight but leaves the outputs alone
    if (flush) begin
      rp_d      = '0;
      wp_d      = '0;
      count_d   = '0;
      bytesel_d = 1'b0;
    end
  end

`ifdef DMASND_UNDERRUN_EN
  always_comb begin
    underrun_d = underrun_q | (aclk_en_q & ~have_data);
    if (flush) begin
      underrun_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      cnt_q      <= '0;
      presc_q    <= '0;
      aclk_en_q  <= 1'b0;
      sload_q    <= 1'b1;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      bytesel_q  <= 1'b0;
      left_q     <= {1'b1, {(OUT_W-1){1'b0}}};
      right_q    <= {1'b1, {(OUT_W-1){1'b0}}};
      strobe_q   <= 1'b0;
`ifdef DMASND_UNDERRUN_EN
      underrun_q <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      aclk_en_q  <= aclk_en_d;
      sload_q    <= sload_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      bytesel_q  <= bytesel_d;
      left_q     <= left_d;
      right_q    <= right_d;
      strobe_q   <= strobe_d;
`ifdef DMASND_UNDERRUN_EN
      underrun_q <= underrun_d;
`endif
    end
  end

  // One slot is held back for a fetch that may already be in flight
  assign SREQ          = (count_q < CW'(DEPTH - 1));
  assign audio_left    = left_q;
  assign audio_right   = right_q;
  assign sample_strobe = strobe_q;
  assign fifo_level    = count_q;
`ifdef DMASND_UNDERRUN_EN
  assign underrun      = underrun_q;
`endif

endmodule
